// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial peripheral chain scheduler.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_t;

    localparam int REQ_LED = 0;
    localparam int REQ_SEG = 1;
    localparam int REQ_LCD = 2;
    localparam int REQ_DIP = 3;
    localparam int NUM_REQ = 4;
    localparam int FRAME_W = 16;

endpackage

// File: rtl/sbus_rr_arbiter.sv
// 4-way round-robin arbiter; the search starts one past the last grant.
module sbus_rr_arbiter
    import serial_bus_pkg::*;
(
    input  logic                       gclk,
    input  logic                       grst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       upd,
    output logic                       vld,
    output logic [1:0]                 idx
);

    logic [1:0] ptr;
    logic [1:0] cand;

    // Pick the first requester after the pointer, wrapping back to the pointer itself.
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + 2'(i);
            if (!vld && req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

    // Remember the winner; resetting to 3 gives LED first turn.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            ptr <= 2'd3;
        else if (upd && vld)
            ptr <= idx;
    end

endmodule

// File: rtl/serial_bus_scheduler.sv
// Arbitrates the single serial chain between LED/SEG/LCD writers and the DIP reader,
// running one complete 16-bit frame (shift + latch) per grant.
module serial_bus_scheduler
    import serial_bus_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic         i_CLK,
    input  logic         i_RESET_n,
    input  logic [3:0]   i_Req,
    input  logic [15:0]  i_LEDData16,
    input  logic [15:0]  i_SEGData16,
    input  logic [15:0]  i_LCDData16,
    output logic [3:0]   o_Grant,
    output logic [3:0]   o_Done,
    output logic [15:0]  o_RData16,
    output logic         o_SCLK,
    output logic         o_SData,
    input  logic         i_SData,
    output logic [3:0]   o_Latch
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    state_t               state, state_nxt;
    logic [DW-1:0]        div_cnt;
    logic [3:0]           bit_cnt;
    logic [1:0]           cur_idx;
    logic [FRAME_W-1:0]   sreg, sreg_nxt, rdata;
    logic                 arb_vld;
    logic [1:0]           arb_idx;
    logic                 bit_end, last_bit, is_dip;
    logic [3:0]           cur_1hot;

    assign bit_end   = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == 4'd15);
    assign is_dip    = (cur_idx == 2'(REQ_DIP));
    assign cur_1hot  = 4'b0001 << cur_idx;
    assign o_RData16 = rdata;

    sbus_rr_arbiter u_arb (
        .gclk   (i_CLK),
        .grst_n (i_RESET_n),
        .req    (i_Req),
        .upd    (state == ST_IDLE),
        .vld    (arb_vld),
        .idx    (arb_idx)
    );

    // State register; reset drops any partial frame straight back to IDLE.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus the chain outputs, all decoded from registered state.
    always_comb begin
        state_nxt = state;
        o_Grant   = '0;
        o_Done    = '0;
        o_Latch   = '0;
        o_SCLK    = 1'b1;
        o_SData   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arb_vld)
                    state_nxt = (arb_idx == 2'(REQ_DIP)) ? ST_LOAD : ST_SHIFT;
            end
            ST_LOAD: begin
                o_Grant = cur_1hot;
                o_Latch = cur_1hot;
                if (bit_end) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                o_Grant = cur_1hot;
                o_SCLK  = (div_cnt >= DIV_HALF);
                o_SData = is_dip ? 1'b0 : sreg[FRAME_W-1];
                if (bit_end && last_bit) state_nxt = is_dip ? ST_DONE : ST_LATCH;
            end
            ST_LATCH: begin
                o_Grant = cur_1hot;
                o_Latch = cur_1hot;
                if (bit_end) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_Done    = cur_1hot;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shift register: payload on grant, shift out at bit end (write) or in on SCLK rise (DIP).
    always_comb begin
        sreg_nxt = sreg;
        if (state == ST_IDLE && arb_vld) begin
            unique case (arb_idx)
                2'(REQ_LED): sreg_nxt = i_LEDData16;
                2'(REQ_SEG): sreg_nxt = i_SEGData16;
                2'(REQ_LCD): sreg_nxt = i_LCDData16;
                default:     sreg_nxt = '0;
            endcase
        end else if (state == ST_SHIFT) begin
            if (is_dip && div_cnt == DIV_HALF)
                sreg_nxt = {sreg[FRAME_W-2:0], i_SData};
            else if (!is_dip && bit_end)
                sreg_nxt = {sreg[FRAME_W-2:0], 1'b0};
        end
    end

    // Bit/cycle counters, captured grant and the DIP result (visible from the DONE cycle).
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            cur_idx <= '0;
            sreg    <= '0;
            rdata   <= '0;
        end else begin
            sreg <= sreg_nxt;
            if (state == ST_IDLE) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                if (arb_vld) cur_idx <= arb_idx;
            end else begin
                div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
                if (state == ST_SHIFT && bit_end) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (is_dip && last_bit) rdata <= sreg_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_bus_scheduler.sv
// Directed bench for serial_bus_scheduler: CLK_DIV=4 main instance, CLK_DIV=2 edge instance.
module tb_serial_bus_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req, req2;
    logic [15:0] led_d, seg_d, lcd_d, led_d2;
    logic        sdi;
    logic [3:0]  grant, done, latch, grant2, done2, latch2;
    logic [15:0] rdata, rdata2;
    logic        sclk, sdo, sclk2, sdo2;

    int n_chk = 0;
    int n_fail = 0;

    serial_bus_scheduler #(.CLK_DIV(4)) u_dut (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_Req(req),
        .i_LEDData16(led_d), .i_SEGData16(seg_d), .i_LCDData16(lcd_d),
        .o_Grant(grant), .o_Done(done), .o_RData16(rdata),
        .o_SCLK(sclk), .o_SData(sdo), .i_SData(sdi), .o_Latch(latch)
    );

    serial_bus_scheduler #(.CLK_DIV(2)) u_dut2 (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_Req(req2),
        .i_LEDData16(led_d2), .i_SEGData16(16'h0000), .i_LCDData16(16'h0000),
        .o_Grant(grant2), .o_Done(done2), .o_RData16(rdata2),
        .o_SCLK(sclk2), .o_SData(sdo2), .i_SData(1'b0), .o_Latch(latch2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one write frame on u_dut (request already presented in cycle 0) and measures it.
    task automatic run_write(input int drop_at, output logic [3:0] g1, output logic [15:0] cap,
                             output int ncap, output int lat_cnt, output logic [3:0] lat_or,
                             output int lat_first, output int done_cyc, output logic [3:0] done_val,
                             output int bad);
        logic prev_sclk;
        prev_sclk = 1'b1; cap = '0; ncap = 0; lat_cnt = 0; lat_or = '0; lat_first = -1;
        done_cyc = -1; done_val = '0; bad = 0; g1 = '0;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            step;
            if (c == drop_at) req = 4'b0000;
            if (c == 1) g1 = grant;
            if (!prev_sclk && sclk) begin cap = {cap[14:0], sdo}; ncap++; end
            prev_sclk = sclk;
            if (latch != 4'b0000) begin
                lat_cnt++; lat_or = lat_or | latch;
                if (lat_first < 0) lat_first = c;
                if (!sclk) bad++;
            end
            if (done != 4'b0000) begin
                done_cyc = c; done_val = done;
                if (grant != 4'b0000) bad++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = '0; req2 = '0; sdi = 1'b0;
        led_d = '0; seg_d = '0; lcd_d = '0; led_d2 = '0;
        #2;
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b exp 0000", grant); end
        n_chk++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b exp 0000", done); end
        n_chk++; if (latch !== 4'b0000) begin n_fail++; $display("FAIL reset_latch: got %b exp 0000", latch); end
        n_chk++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b exp 1", sclk); end
        n_chk++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdata: got %b exp 0", sdo); end
        n_chk++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0000", rdata); end
        step; step;
        rst_n = 1'b1;
    endtask

    task automatic test_led_write;
        logic [3:0] g1, lor, dv; logic [15:0] cap; int ncap, lc, lf, dc, bad;
        step;
        led_d = 16'hA5C3; req = 4'b0001;
        run_write(1, g1, cap, ncap, lc, lor, lf, dc, dv, bad);
        n_chk++; if (g1 !== 4'b0001) begin n_fail++; $display("FAIL led_grant: got %b exp 0001", g1); end
        n_chk++; if (cap !== 16'hA5C3 || ncap != 16) begin n_fail++; $display("FAIL led_data: got %h/%0d exp a5c3/16", cap, ncap); end
        n_chk++; if (lc != 4 || lor !== 4'b0001) begin n_fail++; $display("FAIL led_latch: got %0d/%b exp 4/0001", lc, lor); end
        n_chk++; if (lf != 65) begin n_fail++; $display("FAIL led_latch_rise: got %0d exp 65", lf); end
        n_chk++; if (dc != 69 || dv !== 4'b0001) begin n_fail++; $display("FAIL led_done: got %0d/%b exp 69/0001", dc, dv); end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL led_overlap: got %0d exp 0", bad); end
    endtask

    task automatic test_dip_read;
        logic [15:0] word; logic [15:0] rd_pre, rd_done; logic [3:0] dv;
        int lc, lf, ll, dc;
        word = 16'h3C81; lc = 0; lf = -1; ll = -1; dc = -1; rd_pre = 'x; rd_done = 'x; dv = '0;
        step;
        req = 4'b1000;
        for (int c = 1; c <= 200 && dc < 0; c++) begin
            step;
            if (c == 1) req = 4'b0000;
            if (c >= 5 && c < 69) sdi = word[15 - (c - 5) / 4];
            if (latch[3]) begin lc++; if (lf < 0) lf = c; ll = c; end
            if (c == 68) rd_pre = rdata;
            if (done != 4'b0000) begin dc = c; dv = done; rd_done = rdata; end
        end
        sdi = 1'b0;
        n_chk++; if (lf != 1 || ll != 4 || lc != 4) begin n_fail++; $display("FAIL dip_latch: got %0d..%0d n=%0d exp 1..4 n=4", lf, ll, lc); end
        n_chk++; if (rd_pre !== 16'h0000) begin n_fail++; $display("FAIL dip_rdata_early: got %h exp 0000", rd_pre); end
        n_chk++; if (dc != 69 || dv !== 4'b1000) begin n_fail++; $display("FAIL dip_done: got %0d/%b exp 69/1000", dc, dv); end
        n_chk++; if (rd_done !== 16'h3C81) begin n_fail++; $display("FAIL dip_rdata: got %h exp 3c81", rd_done); end
    endtask

    task automatic test_round_robin;
        logic [3:0] order [5]; logic [3:0] exp_order [5]; logic [3:0] prev_g;
        int ng, bad, first_done, gap, fin;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ng = 0; bad = 0; first_done = -1; gap = -1; fin = 0; prev_g = '0;
        rst_n = 1'b0; step; rst_n = 1'b1;
        led_d = 16'h1111; seg_d = 16'h2222; lcd_d = 16'h3333; req = 4'b1111;
        for (int c = 1; c <= 600 && fin == 0; c++) begin
            step;
            if (grant != 4'b0000 && prev_g == 4'b0000) begin
                if (ng < 5) order[ng] = grant;
                ng++;
                if (first_done >= 0 && gap < 0) gap = c - first_done;
                if (ng == 5) req = 4'b0000;
            end
            prev_g = grant;
            if (grant != 4'b0000 && !$onehot(grant)) bad++;
            if (latch != 4'b0000 && !$onehot(latch)) bad++;
            if (done != 4'b0000) begin
                if (first_done < 0) first_done = c;
                if (ng == 5) fin = 1;
            end
        end
        n_chk++; if (ng != 5 || fin == 0) begin n_fail++; $display("FAIL rr_count: got %0d grants fin=%0d exp 5/1", ng, fin); end
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (order[i] !== exp_order[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %b exp %b", i, order[i], exp_order[i]); end
        end
        n_chk++; if (gap != 2) begin n_fail++; $display("FAIL rr_gap: got %0d exp 2", gap); end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rr_onehot: got %0d violations exp 0", bad); end
    endtask

    task automatic test_withdrawn;
        logic [3:0] g1, lor, dv; logic [15:0] cap; int ncap, lc, lf, dc, bad;
        step;
        seg_d = 16'h00FF; req = 4'b0010;
        run_write(4, g1, cap, ncap, lc, lor, lf, dc, dv, bad);
        n_chk++; if (g1 !== 4'b0010) begin n_fail++; $display("FAIL wd_grant: got %b exp 0010", g1); end
        n_chk++; if (cap !== 16'h00FF || ncap != 16) begin n_fail++; $display("FAIL wd_data: got %h/%0d exp 00ff/16", cap, ncap); end
        n_chk++; if (lc != 4 || lor !== 4'b0010) begin n_fail++; $display("FAIL wd_latch: got %0d/%b exp 4/0010", lc, lor); end
        n_chk++; if (dc != 69 || dv !== 4'b0010) begin n_fail++; $display("FAIL wd_done: got %0d/%b exp 69/0010", dc, dv); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] g1, lor, dv; logic [15:0] cap; int ncap, lc, lf, dc, bad, pre_lat;
        pre_lat = 0;
        step;
        lcd_d = 16'h1234; req = 4'b0100;
        for (int c = 1; c <= 30; c++) begin
            step;
            if (latch != 4'b0000) pre_lat++;
        end
        n_chk++; if (sclk !== 1'b0 || grant !== 4'b0100) begin n_fail++; $display("FAIL mid_pre: got sclk=%b grant=%b exp 0/0100", sclk, grant); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL mid_sclk: got %b exp 1", sclk); end
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mid_grant: got %b exp 0000", grant); end
        n_chk++; if (latch !== 4'b0000 || pre_lat != 0) begin n_fail++; $display("FAIL mid_latch: got %b/%0d exp 0000/0", latch, pre_lat); end
        step;
        rst_n = 1'b1;
        run_write(1, g1, cap, ncap, lc, lor, lf, dc, dv, bad);
        n_chk++; if (g1 !== 4'b0100) begin n_fail++; $display("FAIL mid_regrant: got %b exp 0100", g1); end
        n_chk++; if (cap !== 16'h1234 || ncap != 16) begin n_fail++; $display("FAIL mid_data: got %h/%0d exp 1234/16", cap, ncap); end
        n_chk++; if (lc != 4 || lf != 65 || lor !== 4'b0100) begin n_fail++; $display("FAIL mid_latch_once: got %0d@%0d/%b exp 4@65/0100", lc, lf, lor); end
        n_chk++; if (dc != 69) begin n_fail++; $display("FAIL mid_done: got %0d exp 69", dc); end
    endtask

    task automatic test_div2;
        logic prev_sclk; logic [15:0] cap; int ncap, lc, dc, sbad;
        prev_sclk = 1'b1; cap = '0; ncap = 0; lc = 0; dc = -1; sbad = 0;
        step;
        led_d2 = 16'h8001; req2 = 4'b0001;
        for (int c = 1; c <= 100 && dc < 0; c++) begin
            step;
            if (c == 1) req2 = 4'b0000;
            if (c <= 32 && sclk2 !== ((c % 2) == 0)) sbad++;
            if (!prev_sclk && sclk2) begin cap = {cap[14:0], sdo2}; ncap++; end
            prev_sclk = sclk2;
            if (latch2[0]) lc++;
            if (done2[0]) dc = c;
        end
        n_chk++; if (sbad != 0) begin n_fail++; $display("FAIL div2_sclk: got %0d bad cycles exp 0", sbad); end
        n_chk++; if (cap !== 16'h8001 || ncap != 16) begin n_fail++; $display("FAIL div2_data: got %h/%0d exp 8001/16", cap, ncap); end
        n_chk++; if (lc != 2) begin n_fail++; $display("FAIL div2_latch: got %0d exp 2", lc); end
        n_chk++; if (dc != 35) begin n_fail++; $display("FAIL div2_done: got %0d exp 35", dc); end
    endtask

    initial begin
        test_reset;
        test_led_write;
        test_dip_read;
        test_round_robin;
        test_withdrawn;
        test_reset_mid;
        test_div2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
